// File: rtl/div_unit.sv
// Iterative 32-bit restoring divider (DIV/DIVU) for the E stage.
// One quotient bit per cycle; produces {remainder, quotient} with a one-cycle ready pulse.
module div_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        signed_div,
   input  logic        annul,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [63:0] result,
   output logic        ready,
   output logic        stall_div
);

   localparam int unsigned W  = 32;
   localparam int unsigned CW = 6;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t          state, state_nx;
   logic [CW-1:0]   cnt;
   logic [W-1:0]    rem, quo, dvs;
   logic            q_neg, r_neg;

   logic            accept, last, ge;
   logic [W:0]      trial;
   logic [W-1:0]    rem_nx, quo_nx, q_fin, r_fin, a_mag, b_mag;

   assign accept    = (state == IDLE) && start && !annul;
   assign last      = (cnt == CW'(W - 1));
   // Reset masks an in-flight BUSY stall; an IDLE request still stalls the pipe.
   assign stall_div = accept || ((state == BUSY) && !rst);

   assign a_mag = (signed_div && a[W-1]) ? (W'(0) - a) : a;
   assign b_mag = (signed_div && b[W-1]) ? (W'(0) - b) : b;

   // One restoring step: shift next dividend bit into the partial remainder.
   assign trial  = {rem, quo[W-1]};
   assign ge     = (trial >= {1'b0, dvs});
   assign rem_nx = ge ? W'(trial - {1'b0, dvs}) : trial[W-1:0];
   assign quo_nx = {quo[W-2:0], ge};
   assign q_fin  = q_neg ? (W'(0) - quo_nx) : quo_nx;
   assign r_fin  = r_neg ? (W'(0) - rem_nx) : rem_nx;

   // State register and registered ready pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ready <= 1'b0;
      end else begin
         state <= state_nx;
         ready <= (state_nx == DONE);
      end
   end

   // Next-state logic.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (accept) state_nx = (b == '0) ? DONE : BUSY;
         BUSY: begin
            if (annul)     state_nx = IDLE;
            else if (last) state_nx = DONE;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Operand latch, iteration datapath and result register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= '0;
         rem    <= '0;
         quo    <= '0;
         dvs    <= '0;
         q_neg  <= 1'b0;
         r_neg  <= 1'b0;
         result <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  if (b == '0) begin
                     result <= {a, {W{1'b1}}};
                  end else begin
                     cnt   <= '0;
                     rem   <= '0;
                     quo   <= a_mag;
                     dvs   <= b_mag;
                     q_neg <= signed_div && (a[W-1] ^ b[W-1]);
                     r_neg <= signed_div && a[W-1];
                  end
               end
            end
            BUSY: begin
               if (!annul) begin
                  cnt <= cnt + CW'(1);
                  rem <= rem_nx;
                  quo <= quo_nx;
                  if (last) result <= {r_fin, q_fin};
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: cycle-level reference model plus directed vectors.
// A per-cycle compare checks stall_div, ready and result; directed tasks pin latency and literals.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst, start, signed_div, annul;
   logic [31:0] a_in, b_in;
   logic [63:0] result;
   logic        ready, stall_div;

   int errors = 0;
   int checks = 0;

   div_unit dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .signed_div (signed_div),
      .annul      (annul),
      .a          (a_in),
      .b          (b_in),
      .result     (result),
      .ready      (ready),
      .stall_div  (stall_div)
   );

   always #5 clk = ~clk;

   // Architectural result of DIV/DIVU, including divide-by-zero.
   function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y,
                                           input logic sd);
      logic [31:0] mx, my, q, r;
      if (y == 32'd0) return {x, 32'hFFFF_FFFF};
      mx = (sd && x[31]) ? (32'd0 - x) : x;
      my = (sd && y[31]) ? (32'd0 - y) : y;
      q  = mx / my;
      r  = mx % my;
      if (sd && (x[31] ^ y[31])) q = 32'd0 - q;
      if (sd && x[31])           r = 32'd0 - r;
      return {r, q};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Timeline model: busy-cycles remaining, one-cycle done flag, held result.
   int          m_left  = 0;
   logic        m_rdy   = 1'b0;
   logic        m_valid = 1'b0;
   logic [63:0] m_res   = '0;
   logic [63:0] m_pend  = '0;
   logic        m_idle, exp_stall;

   assign m_idle    = !m_rdy && (m_left == 0);
   assign exp_stall = (m_idle && start && !annul) || ((m_left > 0) && !rst);

   always @(posedge clk) begin
      if (rst) begin
         m_left  <= 0;
         m_rdy   <= 1'b0;
         m_res   <= '0;
         m_valid <= 1'b1;
      end else if (m_rdy) begin
         m_rdy <= 1'b0;
      end else if (m_left > 0) begin
         if (annul) m_left <= 0;
         else if (m_left == 1) begin
            m_left <= 0;
            m_rdy  <= 1'b1;
            m_res  <= m_pend;
         end else m_left <= m_left - 1;
      end else if (start && !annul) begin
         if (b_in == 32'd0) begin
            m_rdy <= 1'b1;
            m_res <= ref_div(a_in, b_in, signed_div);
         end else begin
            m_left <= 32;
            m_pend <= ref_div(a_in, b_in, signed_div);
         end
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("cyc_stall",  64'(stall_div), 64'(exp_stall));
         chk("cyc_ready",  64'(ready),     64'(m_rdy));
         chk("cyc_result", result,         m_res);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one division, measure stall length and ready latency, check the literal result.
   task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic tsd,
                         input logic [63:0] exp, input string name,
                         input int pulse_at, input logic pulse_ann);
      int stalls;
      int rdy_at;
      bit got;
      int exp_lat;
      exp_lat    = (tb_v == 32'd0) ? 1 : 33;
      a_in       = ta;
      b_in       = tb_v;
      signed_div = tsd;
      start      = 1'b1;
      stalls     = 0;
      rdy_at     = 0;
      got        = 1'b0;
      @(negedge clk);
      if (stall_div) stalls++;
      for (int cyc = 1; cyc <= 100 && !got; cyc++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         annul = 1'b0;
         if (cyc == pulse_at) begin
            start = 1'b1;
            annul = pulse_ann;
            a_in  = 32'h1;
            b_in  = 32'h1;
         end
         @(negedge clk);
         if (ready) begin
            got    = 1'b1;
            rdy_at = cyc;
         end else if (stall_div) stalls++;
      end
      if (!got) begin
         errors++;
         $display("FAIL %s_timeout: ready not seen within 100 cycles", name);
      end
      chk({name, "_stalls"},   64'(stalls), 64'(exp_lat));
      chk({name, "_latency"},  64'(rdy_at), 64'(exp_lat));
      chk({name, "_result"},   result,      exp);
      step();
      start = 1'b0;
      annul = 1'b0;
   endtask

   initial begin
      logic seen;
      rst        = 1'b1;
      start      = 1'b0;
      annul      = 1'b0;
      signed_div = 1'b0;
      a_in       = '0;
      b_in       = '0;

      chk("model_u_100_7",   ref_div(32'd100, 32'd7, 1'b0),              {32'd2, 32'd14});
      chk("model_s_m7_2",    ref_div(32'hFFFF_FFF9, 32'd2, 1'b1),        {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      chk("model_s_ovf",     ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1), {32'h0, 32'h8000_0000});

      step();
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("reset_result", result, 64'h0);
      chk("reset_ready",  64'(ready), 64'h0);
      chk("reset_stall",  64'(stall_div), 64'h0);
      step();

      run_op(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, "u_100_7", 0, 1'b0);
      run_op(32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "s_m7_2", 0, 1'b0);
      run_op(32'd7, 32'hFFFF_FFFE, 1'b1, {32'h0000_0001, 32'hFFFF_FFFD}, "s_7_m2", 33, 1'b0);
      run_op(32'd5, 32'd0, 1'b0, {32'h0000_0005, 32'hFFFF_FFFF}, "u_dz", 0, 1'b0);
      run_op(32'd5, 32'd0, 1'b1, {32'h0000_0005, 32'hFFFF_FFFF}, "s_dz", 0, 1'b0);
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0, 32'h8000_0000}, "s_ovf", 33, 1'b1);
      run_op(32'hFFFF_FFFF, 32'h10, 1'b0, {32'h0000_000F, 32'h0FFF_FFFF}, "u_big", 0, 1'b0);

      // Annul mid-division: no ready, previous result retained.
      a_in = 32'd1000; b_in = 32'd3; signed_div = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      repeat (9) step();
      annul = 1'b1;
      step();
      annul = 1'b0;
      @(negedge clk);
      chk("annul_stall",  64'(stall_div), 64'h0);
      chk("annul_result", result, {32'h0000_000F, 32'h0FFF_FFFF});
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (ready) seen = 1'b1;
      end
      chk("annul_no_ready", 64'(seen), 64'h0);
      step();
      run_op(32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, "u_9_3", 0, 1'b0);

      // Annul together with start in IDLE is not accepted.
      a_in = 32'd4; b_in = 32'd2; start = 1'b1; annul = 1'b1;
      @(negedge clk);
      chk("idle_annul_stall", 64'(stall_div), 64'h0);
      step();
      start = 1'b0; annul = 1'b0;
      @(negedge clk);
      chk("idle_annul_not_busy", 64'(stall_div), 64'h0);
      repeat (3) step();

      // Reset in the middle of a division.
      a_in = 32'd100; b_in = 32'd7; start = 1'b1;
      step();
      start = 1'b0;
      repeat (19) step();
      rst = 1'b1;
      @(negedge clk);
      chk("rst_busy_stall", 64'(stall_div), 64'h0);
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_result", result, 64'h0);
      chk("rst_mid_ready",  64'(ready), 64'h0);
      chk("rst_mid_stall",  64'(stall_div), 64'h0);
      step();

      run_op(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, "u_100_7_ign", 5, 1'b0);
      repeat (2) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
